// File: rtl/gpio_proto_pkg.sv
// rtl/gpio_proto_pkg.sv - GPIO convolution protocol bit map and host FSM encoding
package gpio_proto_pkg;

  // Bit positions inside the 32-bit gpio_o_data_tri_o word
  localparam int GPIO_RST      = 0;
  localparam int GPIO_KI       = 1;
  localparam int GPIO_VALID    = 2;
  localparam int GPIO_RSTM     = 3;
  localparam int GPIO_WEN      = 4;
  localparam int GPIO_ADDR_LSB = 8;

  // Host sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_LOAD_K = 3'd2,
    ST_RUN    = 3'd3,
    ST_READ   = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } host_state_e;

endpackage

// File: rtl/gpio_host_seq_if.sv
// rtl/gpio_host_seq_if.sv - GPIO word pair between host sequencer and conv/BRAM wrapper
interface gpio_host_seq_if #(
  parameter int GPIO_D = 32
);

  logic [GPIO_D-1:0] o_gpio;
  logic [GPIO_D-1:0] i_gpio;

  modport master (output o_gpio, input i_gpio);
  modport slave  (input o_gpio, output i_gpio);

endinterface

// File: rtl/gpio_host_seq_rd_pipe.sv
// rtl/gpio_host_seq_rd_pipe.sv - read-back valid/address delay line with result capture
module gpio_rd_pipe #(
  parameter int NB_ADDRESS = 10,
  parameter int RAM_WIDTH  = 13,
  parameter int READ_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  i_clr,
  input  logic                  i_valid,
  input  logic [NB_ADDRESS-1:0] i_addr,
  input  logic [RAM_WIDTH-1:0]  i_data,
  output logic                  o_valid,
  output logic [NB_ADDRESS-1:0] o_addr,
  output logic [RAM_WIDTH-1:0]  o_data
);

  logic [READ_LAT-1:0]                 vld_d, vld_q;
  logic [READ_LAT-1:0][NB_ADDRESS-1:0] addr_d, addr_q;
  logic [RAM_WIDTH-1:0]                data_d, data_q;

  // Shift tags one stage per cycle; the data word is sampled on the edge that loads the last stage
  always_comb begin
    vld_d  = '0;
    addr_d = '0;
    data_d = '0;
    if (!i_clr) begin
      data_d    = data_q;
      vld_d[0]  = i_valid;
      addr_d[0] = i_addr;
      for (int k = 1; k < READ_LAT; k++) begin
        vld_d[k]  = vld_q[k-1];
        addr_d[k] = addr_q[k-1];
      end
      if (vld_d[READ_LAT-1]) begin
        data_d = i_data;
      end
    end
  end

  // Pipe registers; clearing is folded into the next-state logic above
  always_ff @(posedge clk) begin
    vld_q  <= vld_d;
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign o_valid = vld_q[READ_LAT-1];
  assign o_addr  = addr_q[READ_LAT-1];
  assign o_data  = data_q;

endmodule

// File: rtl/gpio_host_seq.sv
// rtl/gpio_host_seq.sv - host-side sequencer driving the GPIO convolution protocol
module gpio_host_seq
  import gpio_proto_pkg::*;
#(
  parameter int GPIO_D     = 32,
  parameter int NB_ADDRESS = 10,
  parameter int RAM_WIDTH  = 13,
  parameter int M_LEN      = 3,
  parameter int RST_CYC    = 4,
  parameter int READ_LAT   = 2
) (
  input  logic                  CLK100MHZ,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [NB_ADDRESS-1:0] i_run_len,
  input  logic [NB_ADDRESS-1:0] i_read_len,
  gpio_host_seq_if.master       gpio,
  output logic [RAM_WIDTH-1:0]  o_rd_data,
  output logic [NB_ADDRESS-1:0] o_rd_addr,
  output logic                  o_rd_valid,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [NB_ADDRESS-1:0] ONE      = NB_ADDRESS'(1);
  localparam logic [NB_ADDRESS-1:0] RST_LAST = NB_ADDRESS'(RST_CYC - 1);
  localparam logic [NB_ADDRESS-1:0] LDK_LAST = NB_ADDRESS'(M_LEN - 1);
  localparam logic [NB_ADDRESS-1:0] DRN_LAST = NB_ADDRESS'(READ_LAT - 1);

  host_state_e           state_d, state_q;
  logic [NB_ADDRESS-1:0] cnt_d, cnt_q;
  logic [NB_ADDRESS-1:0] addr_d, addr_q;
  logic [NB_ADDRESS-1:0] run_len_d, run_len_q;
  logic [NB_ADDRESS-1:0] read_len_d, read_len_q;
  logic [GPIO_D-1:0]     gpio_d, gpio_q;
  logic                  busy_d, busy_q;
  logic                  done_d, done_q;
  logic                  unused_gpio_hi;

  // State, counters and registered outputs; reset restores the idle GPIO word
  always_ff @(posedge CLK100MHZ) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      run_len_q  <= '0;
      read_len_q <= '0;
      gpio_q     <= GPIO_D'(1);
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      run_len_q  <= run_len_d;
      read_len_q <= read_len_d;
      gpio_q     <= gpio_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next state: phase lengths come from the shared cycle counter, READ walks the address counter
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    run_len_d  = run_len_q;
    read_len_d = read_len_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d    = ST_RST;
          cnt_d      = '0;
          run_len_d  = i_run_len;
          read_len_d = i_read_len;
        end
      end
      ST_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_LOAD_K;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_LOAD_K: begin
        if (cnt_q == LDK_LAST) begin
          cnt_d  = '0;
          addr_d = '0;
          if (run_len_q != '0)       state_d = ST_RUN;
          else if (read_len_q != '0) state_d = ST_READ;
          else                       state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_RUN: begin
        if (cnt_q == run_len_q - ONE) begin
          cnt_d   = '0;
          addr_d  = '0;
          state_d = (read_len_q != '0) ? ST_READ : ST_DONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_READ: begin
        if (addr_q == read_len_q - ONE) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          addr_d = addr_q + ONE;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRN_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // GPIO word and status for the state being entered, so every output is a flop
  always_comb begin
    gpio_d = '0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    unique case (state_d)
      ST_IDLE, ST_RST, ST_DONE: gpio_d[GPIO_RST] = 1'b1;
      ST_LOAD_K: gpio_d[GPIO_VALID] = 1'b1;
      ST_RUN: begin
        gpio_d[GPIO_KI]    = 1'b1;
        gpio_d[GPIO_VALID] = 1'b1;
        gpio_d[GPIO_RSTM]  = 1'b1;
        gpio_d[GPIO_WEN]   = 1'b1;
      end
      ST_READ, ST_DRAIN: begin
        gpio_d[GPIO_KI]                          = 1'b1;
        gpio_d[GPIO_ADDR_LSB +: NB_ADDRESS]      = addr_d;
      end
      default: gpio_d[GPIO_RST] = 1'b1;
    endcase
  end

  // An address is in flight for every cycle the READ address sits on the GPIO word
  gpio_rd_pipe #(
    .NB_ADDRESS (NB_ADDRESS),
    .RAM_WIDTH  (RAM_WIDTH),
    .READ_LAT   (READ_LAT)
  ) u_rd_pipe (
    .clk     (CLK100MHZ),
    .i_clr   (!i_reset_n),
    .i_valid (state_q == ST_READ),
    .i_addr  (addr_q),
    .i_data  (gpio.i_gpio[RAM_WIDTH-1:0]),
    .o_valid (o_rd_valid),
    .o_addr  (o_rd_addr),
    .o_data  (o_rd_data)
  );

  assign unused_gpio_hi = ^gpio.i_gpio[GPIO_D-1:RAM_WIDTH];
  assign gpio.o_gpio    = gpio_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_gpio_host_seq.sv
// tb/tb_gpio_host_seq.sv - directed self-checking bench for gpio_host_seq
module tb_gpio_host_seq;

  localparam int RST_CYC  = 4;
  localparam int M_LEN    = 3;
  localparam int READ_LAT = 2;

  logic        CLK100MHZ;
  logic        i_reset_n;
  logic        i_start;
  logic [9:0]  i_run_len;
  logic [9:0]  i_read_len;
  logic [12:0] o_rd_data;
  logic [9:0]  o_rd_addr;
  logic        o_rd_valid;
  logic        o_busy;
  logic        o_done;
  logic [12:0] bram_q;

  int checks = 0;
  int errors = 0;

  gpio_host_seq_if #(.GPIO_D(32)) gif ();

  gpio_host_seq dut (
    .CLK100MHZ  (CLK100MHZ),
    .i_reset_n  (i_reset_n),
    .i_start    (i_start),
    .i_run_len  (i_run_len),
    .i_read_len (i_read_len),
    .gpio       (gif),
    .o_rd_data  (o_rd_data),
    .o_rd_addr  (o_rd_addr),
    .o_rd_valid (o_rd_valid),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  function automatic logic [12:0] mem_f(input logic [9:0] a);
    return ({3'b000, a} * 13'd37) + 13'h0A5;
  endfunction

  // BRAM model: one register stage, so data is ready READ_LAT edges after the address
  always @(posedge CLK100MHZ) bram_q <= mem_f(gif.o_gpio[17:8]);
  assign gif.i_gpio = {19'h0, bram_q};

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_seq(input int rl, input int dl, input int dup_c);
    int c, rst_n, ld, wen, rdc, pulses, first_pc, last_pc, done_c, dones, bad, exp_addr, limit, exp_done;
    logic [9:0]  last_a;
    logic [31:0] g;
    rst_n = 0; ld = 0; wen = 0; rdc = 0; pulses = 0; first_pc = -1; last_pc = -1;
    done_c = -1; dones = 0; bad = 0; exp_addr = 0; last_a = '0;
    limit = RST_CYC + M_LEN + rl + dl + READ_LAT + 10;
    i_run_len  = 10'(rl);
    i_read_len = 10'(dl);
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    c = 0;
    while (dones == 0 && c <= limit) begin
      g = gif.o_gpio;
      if ((g & ~32'h0003_FF1F) != 0) bad++;
      if (g[0] && !o_done) rst_n++;
      if (g[2] && !g[1]) ld++;
      if (g[4]) wen++;
      if (g[1] && !g[2] && !g[0]) begin
        rdc++;
        last_a = g[17:8];
      end
      if (o_rd_valid) begin
        chk("rd_addr", 32'(o_rd_addr), 32'(exp_addr));
        chk("rd_data", 32'(o_rd_data), 32'(mem_f(10'(exp_addr))));
        if (first_pc < 0) first_pc = c;
        last_pc = c;
        pulses++;
        exp_addr++;
      end
      if (o_done) begin
        dones++;
        done_c = c;
      end else begin
        if (c == dup_c) i_start = 1'b1;
        tick();
        i_start = 1'b0;
        c++;
      end
    end
    exp_done = (dl > 0) ? RST_CYC + M_LEN + rl + dl + READ_LAT : RST_CYC + M_LEN + rl;
    chk("done_cycle", 32'(done_c), 32'(exp_done));
    chk("rst_cycles", 32'(rst_n), 32'(RST_CYC));
    chk("loadk_cycles", 32'(ld), 32'(M_LEN));
    chk("wen_cycles", 32'(wen), 32'(rl));
    chk("rd_pulses", 32'(pulses), 32'(dl));
    chk("issue_cycles", 32'(rdc), (dl > 0) ? 32'(dl + READ_LAT) : 32'd0);
    chk("unused_bits", 32'(bad), 32'd0);
    if (dl > 0) begin
      chk("last_addr", 32'(last_a), 32'(dl - 1));
      chk("first_rd_cycle", 32'(first_pc), 32'(RST_CYC + M_LEN + rl + READ_LAT));
      chk("rd_contiguous", 32'(last_pc - first_pc + 1), 32'(dl));
    end
    tick();
    chk("done_one_cycle", 32'(o_done), 32'd0);
    chk("busy_fall", 32'(o_busy), 32'd0);
    chk("gpio_idle", gif.o_gpio, 32'h1);
    repeat (3) tick();
    chk("idle_stay", 32'(o_busy), 32'd0);
  endtask

  initial begin
    int vcnt;
    i_reset_n  = 1'b0;
    i_start    = 1'b0;
    i_run_len  = '0;
    i_read_len = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_gpio", gif.o_gpio, 32'h1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_rd_data", 32'(o_rd_data), 32'd0);
    chk("rst_rd_addr", 32'(o_rd_addr), 32'd0);
    i_reset_n = 1'b1;
    tick();

    // Nominal run
    run_seq(8, 4, -1);
    // Zero run length, then zero read length
    run_seq(0, 5, -1);
    run_seq(3, 0, -1);
    // Start pulsed during RUN must be ignored
    run_seq(8, 4, 9);

    // Reset during READ after two addresses issued
    i_run_len  = 10'd2;
    i_read_len = 10'd6;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (10) tick();
    chk("midread_addr1", 32'(gif.o_gpio[17:8]), 32'd1);
    chk("midread_fields", 32'(gif.o_gpio[4:0]), 32'h02);
    i_reset_n = 1'b0;
    tick();
    chk("midrst_gpio", gif.o_gpio, 32'h1);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_rd_valid", 32'(o_rd_valid), 32'd0);
    i_reset_n = 1'b1;
    vcnt = 0;
    repeat (8) begin
      tick();
      if (o_rd_valid) vcnt++;
    end
    chk("midrst_no_valid", 32'(vcnt), 32'd0);
    run_seq(8, 4, -1);

    // Maximum read length
    run_seq(2, 1023, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
